sm3_pad_core: RTL
=================

// Module: sm3_pad_core
// PURPOSE
//  SM3 message padding stage: takes a byte-granular message stream, appends the 0x80 marker,
//  zero fill and the 64-bit big-endian bit length, and emits 512-bit blocks as DW-bit words.
//  It is the transmitter side of the pad_otpt_* interface that feeds the SM3 expansion core.
// PARAMETERS
//  DW   32   word width of input and output; legal values 32 or 64; WPB = 512/DW words per block
// PORTS
//  clk                  in   1      clock, all logic on rising edge
//  rst_n                in   1      reset, asynchronous, active-low
//  msg_inpt_d_i         in   DW     message word, byte 0 in [DW-1:DW-8] (big-endian)
//  msg_inpt_byte_vld_i  in   DW/8   valid bytes, contiguous from MSB; all ones unless lst
//  msg_inpt_vld_i       in   1      input word valid
//  msg_inpt_lst_i       in   1      last word of message; byte_vld may be 0 (empty tail)
//  msg_inpt_rdy_o       out  1      input word accepted when vld & rdy
//  pad_otpt_d_o         out  DW     padded block word
//  pad_otpt_vld_o       out  1      output word valid
//  pad_otpt_lst_o       out  1      with final word (length LSW) of final block of message
//  pad_otpt_ena_i       in   1      downstream ready; transfer when vld & ena
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, word counter wcnt=0, bit length counter len=0.
//  Output register: one stage; stall = pad_otpt_vld_o & ~pad_otpt_ena_i; while stalled d/lst hold.
//  msg_inpt_rdy_o = (state==IDLE|DATA) & ~stall; accepted word appears on output next cycle.
//  FSM: IDLE -> DATA on first accepted word (same transition rules as DATA).
//   DATA: non-lst word -> emit as-is, len += DW. lst word with k valid bytes (k<DW/8):
//    emit valid bytes, byte k = 0x80, remaining bytes 0, len += 8k -> ZERO. lst with k=DW/8:
//    emit word, len += DW -> ONE.
//   ONE: emit 0x80 followed by DW-8 zero bits -> ZERO.
//   ZERO: emit 0 until wcnt == WPB-64/DW, then -> LEN. If the 0x80 landed at wcnt > WPB-64/DW-1
//    (no room for length) zeros run to wcnt=WPB-1, block ends, next block zeros from wcnt=0.
//   LEN: emit len[63:32] then len[31:0] (DW=32) or len[63:0] (DW=64); lst=1 on final -> IDLE.
//  wcnt increments on each output transfer, wraps WPB-1 -> 0; len zeroed on return to IDLE.
//  FSM only advances when ~stall; input not accepted during ONE/ZERO/LEN.
//  len is mod 2^64 (wrap silently). Empty message: lst with byte_vld=0 in IDLE -> 0x80 word.
//  Reset mid-message: outputs drop to 0 immediately (async), partial block discarded.
// CONFIGURATION
//  `SM3_PAD_PROT_CHK_EN defined: adds output pad_err_o (1 bit, sticky until reset), set when an
//   accepted word has non-contiguous byte_vld, or byte_vld != all-ones without lst; offending
//   word is still padded as if byte_vld were truncated at first 0 bit.
//  Not defined: no pad_err_o port, no checking logic; byte_vld assumed legal.
// STRUCTURE
//  Shared package sm3_pkg: pad_state_e {IDLE,DATA,ONE,ZERO,LEN}, SM3_BLK_BITS=512,
//   SM3_LEN_BITS=64, SM3_PAD_MARK=8'h80.
//  Sub-module sm3_pad_byte_mrg: combinational merge of data, byte_vld and 0x80 marker into
//   one DW word (also produces contiguity flag for the checker).
// TESTING (DW=32 unless noted)
//  "abc": one word 0x61626300, byte_vld=4'b1110, lst -> 0x61626380, 14x 0, 0x00000018 w/ lst.
//  64-byte msg, 16 full words, lst on 16th -> 16 data words, then 0x80000000, 13x 0,
//   0x00000000, 0x00000200 with lst; lst low on word 15 of first block.
//  56-byte msg (14 full words) -> words14..15 = 0x80000000,0; block 2: 14x 0, 0, 0x000001C0+lst.
//  Empty msg: vld+lst, byte_vld=0 -> 0x80000000, 14x 0 incl length MSW, 0x00000000 with lst.
//  Backpressure: ena low 3 cycles mid-block -> d/lst stable, rdy=0, no word lost or duplicated.
//  Reset asserted mid-block then new "abc" -> clean single padded block; `SM3_PAD_PROT_CHK_EN:
//   byte_vld=4'b1010 -> pad_err_o=1 next cycle, stays 1.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 constants and the message-padding FSM state type.
package sm3_pkg;

  localparam int unsigned SM3_BLK_BITS = 512;
  localparam int unsigned SM3_LEN_BITS = 64;
  localparam logic [7:0]  SM3_PAD_MARK = 8'h80;

  typedef enum logic [2:0] {IDLE, DATA, ONE, ZERO, LEN} pad_state_e;

endpackage

// File: rtl/sm3_pad_byte_mrg.sv
// Merges a last message word with its 0x80 marker: keeps the leading run of valid bytes,
// places the marker after it and zeroes the rest. Contiguity flag only with SM3_PAD_PROT_CHK_EN.
module sm3_pad_byte_mrg
  import sm3_pkg::*;
#(
  parameter int unsigned DW = 32,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned CW = $clog2(NB + 1)
) (
  input  logic [DW-1:0] i_d,
  input  logic [NB-1:0] i_byte_vld,
  input  logic          i_lst,
`ifdef SM3_PAD_PROT_CHK_EN
  output logic          o_contig,
`endif
  output logic [DW-1:0] o_d,
  output logic [CW-1:0] o_nbytes
);

  logic          w_run;
  logic [DW-1:0] w_pad;

  // Byte count stops at the first invalid byte, which is where the marker goes.
  always_comb begin
    w_pad    = '0;
    o_nbytes = '0;
    w_run    = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (w_run && i_byte_vld[NB-1-b]) begin
        w_pad[DW-1-8*b -: 8] = i_d[DW-1-8*b -: 8];
        o_nbytes = o_nbytes + CW'(1);
      end else if (w_run) begin
        w_pad[DW-1-8*b -: 8] = SM3_PAD_MARK;
        w_run = 1'b0;
      end
    end
  end

  assign o_d = i_lst ? w_pad : i_d;

`ifdef SM3_PAD_PROT_CHK_EN
  logic [NB-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < NB; b++) begin
      w_mask[NB-1-b] = (b < int'(o_nbytes));
    end
  end

  assign o_contig = (w_mask == i_byte_vld);
`endif

endmodule

// File: rtl/sm3_pad_core.sv
// SM3 padding stage: appends 0x80, zero fill and 64-bit bit length, emitting 512-bit blocks
// as DW-bit words. Define SM3_PAD_PROT_CHK_EN to add the sticky pad_err_o byte_vld checker.
module sm3_pad_core
  import sm3_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   msg_inpt_d_i,
  input  logic [DW/8-1:0] msg_inpt_byte_vld_i,
  input  logic            msg_inpt_vld_i,
  input  logic            msg_inpt_lst_i,
  output logic            msg_inpt_rdy_o,
  output logic [DW-1:0]   pad_otpt_d_o,
  output logic            pad_otpt_vld_o,
  output logic            pad_otpt_lst_o,
`ifdef SM3_PAD_PROT_CHK_EN
  output logic            pad_err_o,
`endif
  input  logic            pad_otpt_ena_i
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned CW  = $clog2(NB + 1);
  localparam int unsigned WPB = SM3_BLK_BITS / DW;
  localparam int unsigned LW  = SM3_LEN_BITS / DW;
  localparam int unsigned WCW = $clog2(WPB);
  localparam logic [WCW-1:0] PRE_LEN  = WCW'(WPB - LW - 1);
  localparam logic [WCW-1:0] LAST_POS = WCW'(WPB - 1);

  pad_state_e    r_state, w_state_nxt;
  logic [WCW-1:0] r_wcnt;
  logic [63:0]   r_len;
  logic [DW-1:0] r_d;
  logic          r_vld, r_lst;

  logic          w_stall, w_acc, w_emit, w_lst;
  logic [DW-1:0] w_d, w_mrg_d;
  logic [CW-1:0] w_nbytes;
  logic [63:0]   w_len_add;
`ifdef SM3_PAD_PROT_CHK_EN
  logic          w_contig;
`endif

  sm3_pad_byte_mrg #(
    .DW (DW)
  ) u_mrg (
    .i_d        (msg_inpt_d_i),
    .i_byte_vld (msg_inpt_byte_vld_i),
    .i_lst      (msg_inpt_lst_i),
`ifdef SM3_PAD_PROT_CHK_EN
    .o_contig   (w_contig),
`endif
    .o_d        (w_mrg_d),
    .o_nbytes   (w_nbytes)
  );

  assign w_stall        = r_vld & ~pad_otpt_ena_i;
  assign msg_inpt_rdy_o = ((r_state == IDLE) || (r_state == DATA)) && !w_stall;
  assign w_acc          = msg_inpt_vld_i & msg_inpt_rdy_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // r_wcnt is the block position of the word being generated this cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_stall) begin
      unique case (r_state)
        IDLE, DATA: begin
          if (w_acc) begin
            if (!msg_inpt_lst_i)           w_state_nxt = DATA;
            else if (w_nbytes == CW'(NB))  w_state_nxt = ONE;
            else                           w_state_nxt = (r_wcnt == PRE_LEN) ? LEN : ZERO;
          end
        end
        ONE:     w_state_nxt = (r_wcnt == PRE_LEN) ? LEN : ZERO;
        ZERO:    if (r_wcnt == PRE_LEN) w_state_nxt = LEN;
        LEN:     if (r_wcnt == LAST_POS) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_emit    = 1'b0;
    w_d       = '0;
    w_lst     = 1'b0;
    w_len_add = '0;
    unique case (r_state)
      IDLE, DATA: begin
        if (w_acc) begin
          w_emit    = 1'b1;
          w_d       = w_mrg_d;
          w_len_add = msg_inpt_lst_i ? (64'(w_nbytes) << 3) : 64'(DW);
        end
      end
      ONE: begin
        w_emit = 1'b1;
        w_d    = {SM3_PAD_MARK, {(DW-8){1'b0}}};
      end
      ZERO:    w_emit = 1'b1;
      LEN: begin
        w_emit = 1'b1;
        w_lst  = (r_wcnt == LAST_POS);
        w_d    = (r_wcnt == LAST_POS) ? DW'(r_len) : DW'(r_len >> DW);
      end
      default: w_emit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_d    <= '0;
      r_lst  <= 1'b0;
      r_wcnt <= '0;
      r_len  <= '0;
    end else if (!w_stall) begin
      r_vld <= w_emit;
      r_d   <= w_d;
      r_lst <= w_lst;
      if (w_emit) r_wcnt <= r_wcnt + WCW'(1);
      if (w_lst)  r_len  <= '0;
      else        r_len  <= r_len + w_len_add;
    end
  end

  assign pad_otpt_d_o   = r_d;
  assign pad_otpt_vld_o = r_vld;
  assign pad_otpt_lst_o = r_lst;

`ifdef SM3_PAD_PROT_CHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_acc && (!w_contig || (!msg_inpt_lst_i && !(&msg_inpt_byte_vld_i)))) begin
      r_err <= 1'b1;
    end
  end

  assign pad_err_o = r_err;
`endif

endmodule
